pov_frame_sequencer: RTL and testbench

Parametrised frame sequencer and texture-address generator for the persistence-of-vision display. It sits between `angle_mapper`, `neopixel_controller` and the texture `ROM`, and takes over the inline frame-timer and address arithmetic in the top level. Over the fixed loop-only mapping it adds:
- playback modes (loop, ping-pong, one-shot, hold);
- a run-time angular offset;
- restart and pause;
- frame changes committed only at a revolution boundary, so a frame never tears mid-sweep.

---
 rtl/pov_frame_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_pov_frame_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pov_frame_sequencer.sv
// Frame sequencer and texture-address generator for the POV display.
// Optional build macro POV_TEAR_SYNC_EN: frame commits wait for rev_start so a frame never tears mid-sweep.
module pov_frame_sequencer #(
  parameter int LED_COUNT  = 52,
  parameter int TEX_WIDTH  = 64,
  parameter int NUM_FRAMES = 30,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FPS        = 15,
  parameter int THETA_BITS = 6,
  parameter int PX_BITS    = 6,
  parameter int ADDR_BITS  = $clog2(TEX_WIDTH * LED_COUNT * NUM_FRAMES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [THETA_BITS-1:0] theta,
  input  logic                  rev_start,
  input  logic [PX_BITS-1:0]    px_num,
  input  logic [THETA_BITS-1:0] theta_offset,
  input  logic [1:0]            mode,
  input  logic                  play,
  input  logic                  restart,
  output logic [ADDR_BITS-1:0]  rom_addr,
  output logic [7:0]            frame_idx,
  output logic                  frame_tick,
  output logic                  done
);

  localparam int CYC_PER_FRAME = CLK_FREQ / FPS;
  localparam int TMR_BITS      = (CYC_PER_FRAME > 1) ? $clog2(CYC_PER_FRAME) : 1;
  localparam int FRAME_SZ      = TEX_WIDTH * LED_COUNT;

  localparam logic [TMR_BITS-1:0]  TMR_LAST   = TMR_BITS'(CYC_PER_FRAME - 1);
  localparam logic [TMR_BITS-1:0]  TMR_ONE    = TMR_BITS'(1'b1);
  localparam logic [TMR_BITS-1:0]  TMR_ZERO   = TMR_BITS'(1'b0);
  localparam logic [ADDR_BITS-1:0] FRAME_SZ_C = ADDR_BITS'(FRAME_SZ);
  localparam logic [ADDR_BITS-1:0] ADDR_ZERO  = ADDR_BITS'(1'b0);
  localparam logic [7:0]           LAST_IDX   = 8'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_LOOP    = 2'b00,
    MODE_PING    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  mode_e                 mode_s;
  logic                  run_s;
  logic                  expire_s;
  logic                  commit_s;
  logic                  change_s;
  logic [TMR_BITS-1:0]   timer_r;
  logic [TMR_BITS-1:0]   timer_nxt_s;
  logic [7:0]            idx_r;
  logic [7:0]            idx_nxt_s;
  logic [ADDR_BITS-1:0]  base_r;
  logic [ADDR_BITS-1:0]  base_nxt_s;
  logic                  dir_r;
  logic                  dir_nxt_s;
  logic                  done_r;
  logic                  done_nxt_s;
  logic                  tick_pre_r;
  logic [THETA_BITS-1:0] col_s;
  logic [ADDR_BITS-1:0]  row_off_s;
  logic [ADDR_BITS-1:0]  addr_nxt_s;

  assign mode_s = mode_e'(mode);

  // Frame timer: advance while playing and not holding; wrap at terminal count.
  always_comb begin
    run_s       = play && (mode_s != MODE_HOLD);
    expire_s    = 1'b0;
    timer_nxt_s = timer_r;
    if (run_s) begin
      if (timer_r == TMR_LAST) begin
        expire_s    = 1'b1;
        timer_nxt_s = TMR_ZERO;
      end else begin
        timer_nxt_s = timer_r + TMR_ONE;
      end
    end else begin
      timer_nxt_s = timer_r;
    end
  end

`ifdef POV_TEAR_SYNC_EN
  logic pending_r;
  logic pending_nxt_s;

  // Commit waits for the revolution boundary; expiries saturate into one pending advance.
  always_comb begin
    commit_s      = (pending_r || expire_s) && rev_start && (mode_s != MODE_HOLD) && !done_r;
    pending_nxt_s = pending_r;
    if (commit_s) begin
      pending_nxt_s = 1'b0;
    end else if (expire_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end
`else
  logic rev_start_unused_s;
  assign rev_start_unused_s = rev_start;

  // Without tear sync the timer expiry itself commits the next frame.
  always_comb begin
    commit_s = expire_s && !done_r;
  end
`endif

  // Next frame index, base and direction for the current mode.
  always_comb begin
    idx_nxt_s  = idx_r;
    base_nxt_s = base_r;
    dir_nxt_s  = dir_r;
    done_nxt_s = done_r;
    case (mode_s)
      MODE_LOOP: begin
        if (idx_r == LAST_IDX) begin
          idx_nxt_s  = 8'd0;
          base_nxt_s = ADDR_ZERO;
        end else begin
          idx_nxt_s  = idx_r + 8'd1;
          base_nxt_s = base_r + FRAME_SZ_C;
        end
      end
      MODE_PING: begin
        if (dir_r) begin
          if (idx_r == LAST_IDX) begin
            dir_nxt_s  = 1'b0;
            idx_nxt_s  = idx_r - 8'd1;
            base_nxt_s = base_r - FRAME_SZ_C;
          end else begin
            idx_nxt_s  = idx_r + 8'd1;
            base_nxt_s = base_r + FRAME_SZ_C;
          end
        end else begin
          if (idx_r == 8'd0) begin
            dir_nxt_s  = 1'b1;
            idx_nxt_s  = 8'd1;
            base_nxt_s = base_r + FRAME_SZ_C;
          end else begin
            idx_nxt_s  = idx_r - 8'd1;
            base_nxt_s = base_r - FRAME_SZ_C;
          end
        end
      end
      MODE_ONESHOT: begin
        if (idx_r == LAST_IDX) begin
          done_nxt_s = 1'b1;
        end else begin
          idx_nxt_s  = idx_r + 8'd1;
          base_nxt_s = base_r + FRAME_SZ_C;
          done_nxt_s = (idx_r + 8'd1 == LAST_IDX);
        end
      end
      MODE_HOLD: begin
        idx_nxt_s = idx_r;
      end
      default: begin
        idx_nxt_s = idx_r;
      end
    endcase
    change_s = commit_s && (idx_nxt_s != idx_r);
  end

  // Texture address: frame base plus row (shift) plus wrapped column.
  always_comb begin
    col_s      = theta + theta_offset;
    row_off_s  = ADDR_BITS'(px_num) << THETA_BITS;
    addr_nxt_s = base_r + row_off_s + ADDR_BITS'(col_s);
  end

  // Sequencer state; restart returns to frame 0 and beats a coincident commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r    <= TMR_ZERO;
      idx_r      <= 8'd0;
      base_r     <= ADDR_ZERO;
      dir_r      <= 1'b1;
      done_r     <= 1'b0;
      tick_pre_r <= 1'b0;
`ifdef POV_TEAR_SYNC_EN
      pending_r  <= 1'b0;
`endif
    end else if (restart) begin
      timer_r    <= TMR_ZERO;
      idx_r      <= 8'd0;
      base_r     <= ADDR_ZERO;
      dir_r      <= 1'b1;
      done_r     <= 1'b0;
      tick_pre_r <= 1'b0;
`ifdef POV_TEAR_SYNC_EN
      pending_r  <= 1'b0;
`endif
    end else begin
      timer_r    <= timer_nxt_s;
      tick_pre_r <= change_s;
`ifdef POV_TEAR_SYNC_EN
      pending_r  <= pending_nxt_s;
`endif
      if (commit_s) begin
        idx_r  <= idx_nxt_s;
        base_r <= base_nxt_s;
        dir_r  <= dir_nxt_s;
        done_r <= done_nxt_s;
      end else begin
        idx_r  <= idx_r;
        base_r <= base_r;
        dir_r  <= dir_r;
        done_r <= done_r;
      end
    end
  end

  // Registered outputs; frame_tick lines up with the first address of the new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr   <= ADDR_ZERO;
      frame_tick <= 1'b0;
    end else if (restart) begin
      rom_addr   <= addr_nxt_s;
      frame_tick <= 1'b0;
    end else begin
      rom_addr   <= addr_nxt_s;
      frame_tick <= tick_pre_r;
    end
  end

  assign frame_idx = idx_r;
  assign done      = done_r;

endmodule

// File: tb/tb_pov_frame_sequencer.sv
// Directed self-checking bench for pov_frame_sequencer (10 cycles/frame, 4 frames of 4x8 texels).
module tb_pov_frame_sequencer;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    theta;
  logic          rev_start;
  logic [1:0]    px_num;
  logic [2:0]    theta_offset;
  logic [1:0]    mode;
  logic          play;
  logic          restart;
  logic [AW-1:0] rom_addr;
  logic [7:0]    frame_idx;
  logic          frame_tick;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  pov_frame_sequencer #(
    .LED_COUNT(4), .TEX_WIDTH(8), .NUM_FRAMES(4), .CLK_FREQ(100), .FPS(10),
    .THETA_BITS(3), .PX_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .theta(theta), .rev_start(rev_start), .px_num(px_num),
    .theta_offset(theta_offset), .mode(mode), .play(play), .restart(restart),
    .rom_addr(rom_addr), .frame_idx(frame_idx), .frame_tick(frame_tick), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int changes;
    int ticks;
    bit chg_now;
    bit chg_prev;
    int pp_exp[7];

    reset = 1'b0; restart = 1'b0; rev_start = 1'b0; play = 1'b0; mode = 2'b00;
    theta = 3'd0; theta_offset = 3'd0; px_num = 2'd0;
    #2;
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_frame_idx", frame_idx, 0);
    check_eq("rst_frame_tick", frame_tick, 0);
    check_eq("rst_done", done, 0);
    step(2);
    reset = 1'b1;
    step(1);

    // address arithmetic, frame 0 then frame 2
    px_num = 2'd3; theta = 3'd6; theta_offset = 3'd5;
    step(1);
    check_eq("addr_f0", rom_addr, 27);
    mode = 2'b00; play = 1'b1; rev_start = 1'b1;
    step(20);
    check_eq("addr_f2_idx", frame_idx, 2);
    check_eq("addr_f2_prelat", rom_addr, 59);
    check_eq("addr_f2_tick_early", frame_tick, 0);
    play = 1'b0;
    step(1);
    check_eq("addr_f2", rom_addr, 91);
    check_eq("addr_f2_tick", frame_tick, 1);

    // loop with rev_start every 25 cycles
    rev_start = 1'b0;
    pulse_restart();
    check_eq("loop_restart_idx", frame_idx, 0);
    play = 1'b1;
    prev = 0; changes = 0; chg_prev = 1'b0;
    for (int c = 0; c < 110; c++) begin
      rev_start = ((c % 25) == 24);
      step(1);
      chg_now = 1'b0;
      if (int'(frame_idx) != prev) begin
        chg_now = 1'b1;
        changes++;
        check_eq("loop_seq", frame_idx, (prev + 1) % 4);
`ifdef POV_TEAR_SYNC_EN
        check_eq("loop_on_rev", rev_start, 1);
`endif
        prev = int'(frame_idx);
      end
      if (frame_tick || chg_prev) check_eq("loop_tick_align", frame_tick, chg_prev);
      chg_prev = chg_now;
    end
`ifdef POV_TEAR_SYNC_EN
    check_eq("loop_changes", changes, 4);
    check_eq("loop_final", frame_idx, 0);
`else
    check_eq("loop_changes", changes, 11);
    check_eq("loop_final", frame_idx, 3);
`endif

    // ping-pong, rev_start every cycle
    rev_start = 1'b1; mode = 2'b01;
    pulse_restart();
    check_eq("pp_start", frame_idx, 0);
    pp_exp = '{1, 2, 3, 2, 1, 0, 1};
    for (int k = 0; k < 7; k++) begin
      step(10);
      check_eq("pp_seq", frame_idx, pp_exp[k]);
    end

    // one-shot
    mode = 2'b10;
    pulse_restart();
    step(20);
    check_eq("os_mid_idx", frame_idx, 2);
    check_eq("os_mid_done", done, 0);
    step(10);
    check_eq("os_end_idx", frame_idx, 3);
    check_eq("os_end_done", done, 1);
    step(1);
    ticks = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      ticks += int'(frame_tick);
    end
    check_eq("os_no_more_ticks", ticks, 0);
    check_eq("os_stuck_idx", frame_idx, 3);
    play = 1'b0;
    pulse_restart();
    check_eq("os_restart_idx", frame_idx, 0);
    check_eq("os_restart_done", done, 0);
    check_eq("os_restart_tick", frame_tick, 0);
    step(1);
    check_eq("os_restart_tick2", frame_tick, 0);

    // pause then hold; timer must resume from its held value
    mode = 2'b00;
    pulse_restart();
    play = 1'b1;
    step(5);
    play = 1'b0;
    step(50);
    check_eq("pause_idx", frame_idx, 0);
    play = 1'b1;
    step(4);
    check_eq("pause_resume_pre", frame_idx, 0);
    step(1);
    check_eq("pause_resume", frame_idx, 1);
    step(3);
    mode = 2'b11;
    step(50);
    check_eq("hold_idx", frame_idx, 1);
    mode = 2'b00;
    step(6);
    check_eq("hold_resume_pre", frame_idx, 1);
    step(1);
    check_eq("hold_resume", frame_idx, 2);

    // async reset mid-timer at frame 2
    step(3);
    check_eq("areset_pre_idx", frame_idx, 2);
    check_eq("areset_pre_addr", rom_addr, 91);
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset_addr", rom_addr, 0);
    check_eq("areset_idx", frame_idx, 0);
    check_eq("areset_tick", frame_tick, 0);
    check_eq("areset_done", done, 0);
    #2;
    reset = 1'b1;
    step(1);
    check_eq("areset_release_idx", frame_idx, 0);

    // restart coincident with rev_start
    mode = 2'b00; play = 1'b1; rev_start = 1'b0;
    step(10);
`ifdef POV_TEAR_SYNC_EN
    check_eq("rr_pending_idx", frame_idx, 0);
`else
    check_eq("rr_pending_idx", frame_idx, 1);
`endif
    restart = 1'b1; rev_start = 1'b1;
    step(1);
    restart = 1'b0;
    check_eq("rr_idx", frame_idx, 0);
    check_eq("rr_tick", frame_tick, 0);
    step(1);
    check_eq("rr_idx2", frame_idx, 0);
    check_eq("rr_tick2", frame_tick, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
